// File: rtl/delay_buffer.sv
// delay_buffer: stores each accepted audio sample in a circular memory and
// emits a burst of 16 lag products x[n]*x[n-L_k], tagged with k, for the
// pitch-detection comparator. A 17-bit window counter accompanies each burst.
// Optional feature: define DELAYBUFF_DC_BLOCK_EN to insert a one-pole DC
// blocker ahead of the buffer; without it the raw sample is used.
module delay_buffer #(
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LAG_BASE   = 32,
    parameter int LAG_STEP   = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    output logic [35:0]         delaybuff_o,
    output logic                db_valid_o,
    output logic [16:0]         counter_o
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int FILL_W  = DEPTH_LOG2 + 1;
    localparam int PROD_W  = 32;
    localparam int MAX_LAG = LAG_BASE + 15 * LAG_STEP;

    generate
        if (MAX_LAG >= DEPTH) begin : g_lag_check
            $error("delay_buffer: maximum lag must be smaller than the buffer depth");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   k_q, k_d;
    logic                         ready_q;
    logic                         accept_s;

    logic [DEPTH_LOG2-1:0]        wr_ptr_q, base_ptr_q;
    logic [FILL_W-1:0]            fill_q, fill_base_q;
    logic [16:0]                  counter_q;
    logic signed [SAMPLE_W-1:0]   cur_q;
    logic signed [SAMPLE_W-1:0]   store_s;

    logic [FILL_W-1:0]            lag_s;
    logic [DEPTH_LOG2-1:0]        rd_addr_s;

    logic                         s1_valid_q, s1_zero_q;
    logic [3:0]                   s1_tag_q;
    logic [DEPTH_LOG2-1:0]        s1_addr_q;
    logic                         s2_valid_q, s2_zero_q;
    logic [3:0]                   s2_tag_q;
    logic signed [SAMPLE_W-1:0]   rd_data_q;
    logic                         db_valid_q;
    logic [35:0]                  delaybuff_q;

    logic signed [PROD_W-1:0]     cur_ext_s, dly_ext_s, prod_s, out_prod_s;
    logic signed [SAMPLE_W-1:0]   mem_q [DEPTH];

    // The reset cycle never consumes a sample.
    assign accept_s = sample_valid_i & ready_q & ~reset_i;

`ifdef DELAYBUFF_DC_BLOCK_EN
    localparam int ACC_W = SAMPLE_W + 8;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    logic signed [ACC_W-1:0] dc_q, x_ext_s, diff_s;

    // DC blocker output: input minus the leaky average, saturated to sample range.
    always_comb begin
        x_ext_s = ACC_W'($signed(sample_i));
        diff_s  = x_ext_s - (dc_q >>> 8);
        if (diff_s > SAT_HI) begin
            store_s = SAT_HI[SAMPLE_W-1:0];
        end else if (diff_s < SAT_LO) begin
            store_s = SAT_LO[SAMPLE_W-1:0];
        end else begin
            store_s = diff_s[SAMPLE_W-1:0];
        end
    end

    // DC accumulator integrates the unsaturated difference on every accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dc_q <= {ACC_W{1'b0}};
        end else if (accept_s) begin
            dc_q <= dc_q + diff_s;
        end else begin
            dc_q <= dc_q;
        end
    end
`else
    // Without the DC blocker the raw sample is stored and multiplied.
    always_comb begin
        store_s = sample_i;
    end
`endif

    // Next-state logic: IDLE waits for a sample, EMIT issues 16 reads, DRAIN covers the 2-deep pipeline tail.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EMIT;
                    k_d     = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (k_q == 4'd15) begin
                    state_d = ST_DRAIN;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (k_q == 4'd1) begin
                    state_d = ST_IDLE;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = 4'd0;
            end
        endcase
    end

    // State register; ready is registered from the next state so it is glitch-free.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            k_q     <= 4'd0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Per-sample bookkeeping captured at accept and held for the whole burst.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
            base_ptr_q  <= {DEPTH_LOG2{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            fill_base_q <= {FILL_W{1'b0}};
            counter_q   <= 17'd0;
            cur_q       <= {SAMPLE_W{1'b0}};
        end else if (accept_s) begin
            wr_ptr_q    <= wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            base_ptr_q  <= wr_ptr_q;
            fill_base_q <= fill_q;
            fill_q      <= (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + {{(FILL_W-1){1'b0}}, 1'b1};
            counter_q   <= (counter_q == 17'd65536) ? 17'd1 : counter_q + 17'd1;
            cur_q       <= store_s;
        end else begin
            wr_ptr_q    <= wr_ptr_q;
            base_ptr_q  <= base_ptr_q;
            fill_base_q <= fill_base_q;
            fill_q      <= fill_q;
            counter_q   <= counter_q;
            cur_q       <= cur_q;
        end
    end

    // Lag for the tag currently being issued and the delayed-sample address.
    always_comb begin
        lag_s     = FILL_W'(LAG_BASE) + FILL_W'(k_q) * FILL_W'(LAG_STEP);
        rd_addr_s = base_ptr_q - lag_s[DEPTH_LOG2-1:0];
    end

    // Sample memory: write on accept, registered read; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= store_s;
        end
        rd_data_q <= mem_q[s1_addr_q];
    end

    // Signed product of current and delayed samples, zeroed while warming up.
    always_comb begin
        cur_ext_s  = {{(PROD_W-SAMPLE_W){cur_q[SAMPLE_W-1]}}, cur_q};
        dly_ext_s  = {{(PROD_W-SAMPLE_W){rd_data_q[SAMPLE_W-1]}}, rd_data_q};
        prod_s     = cur_ext_s * dly_ext_s;
        if (s2_zero_q) begin
            out_prod_s = {PROD_W{1'b0}};
        end else begin
            out_prod_s = prod_s;
        end
    end

    // Three-stage product pipeline: address register, RAM read, product register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_tag_q    <= 4'd0;
            s1_addr_q   <= {DEPTH_LOG2{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_tag_q    <= 4'd0;
            db_valid_q  <= 1'b0;
            delaybuff_q <= 36'd0;
        end else begin
            s1_valid_q  <= (state_q == ST_EMIT);
            s1_zero_q   <= (fill_base_q < lag_s);
            s1_tag_q    <= k_q;
            s1_addr_q   <= rd_addr_s;
            s2_valid_q  <= s1_valid_q;
            s2_zero_q   <= s1_zero_q;
            s2_tag_q    <= s1_tag_q;
            db_valid_q  <= s2_valid_q;
            if (s2_valid_q) begin
                delaybuff_q <= {s2_tag_q, out_prod_s};
            end else begin
                delaybuff_q <= delaybuff_q;
            end
        end
    end

    assign sample_ready_o = ready_q;
    assign db_valid_o     = db_valid_q;
    assign delaybuff_o    = delaybuff_q;
    assign counter_o      = counter_q;

endmodule
